// File: rtl/sram_denetleyici.sv
// Requester-side controller for a single-port RW SRAM macro with masked writes and a spare bit.
// Read data lands in a small response FIFO; request acceptance is credit-limited so nothing is dropped.
module sram_denetleyici #(
   parameter int DATA_WIDTH     = 113,
   parameter int NUM_WMASKS     = 14,
   parameter int ADDR_WIDTH     = 8,
   parameter int YANIT_DERINLIK = 3
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic                  istek_gecerli_i,
   output logic                  istek_hazir_o,
   input  logic                  istek_yaz_i,
   input  logic [ADDR_WIDTH-1:0] istek_adres_i,
   input  logic [DATA_WIDTH-1:0] istek_veri_i,
   input  logic [NUM_WMASKS-1:0] istek_maske_i,
   input  logic                  istek_yedek_yaz_i,
   output logic                  yanit_gecerli_o,
   input  logic                  yanit_hazir_i,
   output logic [DATA_WIDTH-1:0] yanit_veri_o,
   output logic                  sram_csb_o,
   output logic                  sram_web_o,
   output logic [NUM_WMASKS-1:0] sram_wmask_o,
   output logic                  sram_spare_wen_o,
   output logic [ADDR_WIDTH-1:0] sram_addr_o,
   output logic [DATA_WIDTH-1:0] sram_din_o,
   input  logic [DATA_WIDTH-1:0] sram_dout_i
);

   localparam int CNT_W = $clog2(YANIT_DERINLIK + 1);
   localparam int PTR_W = $clog2(YANIT_DERINLIK);

   logic [CNT_W-1:0]      doluluk;
   logic                  ucusta;
   logic [PTR_W-1:0]      rd_ptr;
   logic [PTR_W-1:0]      wr_ptr;
   logic [DATA_WIDTH-1:0] kuyruk [YANIT_DERINLIK];
   logic [CNT_W:0]        kredi;
   logic                  kabul;
   logic                  yazma;
   logic                  push;
   logic                  pop;

   function automatic logic [PTR_W-1:0] sonraki(input logic [PTR_W-1:0] ptr);
      if (ptr == PTR_W'(YANIT_DERINLIK - 1)) begin
         return '0;
      end
      return ptr + 1'b1;
   endfunction

   // An in-flight read already owns a FIFO slot, so it counts against the credit.
   assign kredi         = {1'b0, doluluk} + {{CNT_W{1'b0}}, ucusta};
   assign istek_hazir_o = rstn_i && (kredi < (CNT_W+1)'(YANIT_DERINLIK));
   assign kabul         = istek_gecerli_i && istek_hazir_o;
   assign yazma         = kabul && istek_yaz_i;

   assign sram_csb_o       = !kabul;
   assign sram_web_o       = !yazma;
   assign sram_wmask_o     = yazma ? istek_maske_i : '0;
   assign sram_spare_wen_o = yazma && istek_yedek_yaz_i;
   assign sram_addr_o      = istek_adres_i;
   assign sram_din_o       = istek_veri_i;

   assign push            = ucusta;
   assign yanit_gecerli_o = (doluluk != '0);
   assign pop             = yanit_gecerli_o && yanit_hazir_i;
   assign yanit_veri_o    = yanit_gecerli_o ? kuyruk[rd_ptr] : '0;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         ucusta  <= 1'b0;
         doluluk <= '0;
         rd_ptr  <= '0;
         wr_ptr  <= '0;
      end else begin
         ucusta <= kabul && !istek_yaz_i;
         if (push) begin
            wr_ptr <= sonraki(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= sonraki(rd_ptr);
         end
         case ({push, pop})
            2'b10:   doluluk <= doluluk + 1'b1;
            2'b01:   doluluk <= doluluk - 1'b1;
            default: doluluk <= doluluk;
         endcase
      end
   end

   // Storage needs no reset: entries are only visible while counted in doluluk.
   always_ff @(posedge clk_i) begin
      if (push) begin
         kuyruk[wr_ptr] <= sram_dout_i;
      end
   end

endmodule

// File: tb/tb_sram_denetleyici.sv
// Directed bench for sram_denetleyici with a behavioural single-port macro model.
module tb_sram_denetleyici;

   logic         clk_i = 1'b0;
   logic         rstn_i;
   logic         istek_gecerli_i;
   logic         istek_hazir_o;
   logic         istek_yaz_i;
   logic [7:0]   istek_adres_i;
   logic [112:0] istek_veri_i;
   logic [13:0]  istek_maske_i;
   logic         istek_yedek_yaz_i;
   logic         yanit_gecerli_o;
   logic         yanit_hazir_i;
   logic [112:0] yanit_veri_o;
   logic         sram_csb_o;
   logic         sram_web_o;
   logic [13:0]  sram_wmask_o;
   logic         sram_spare_wen_o;
   logic [7:0]   sram_addr_o;
   logic [112:0] sram_din_o;
   logic [112:0] sram_dout_i;

   int n_checks = 0;
   int n_errors = 0;
   int acc_cnt  = 0;
   logic ovf = 1'b0;
   logic [112:0] mem [256];
   logic [112:0] w;

   sram_denetleyici dut (
      .clk_i(clk_i), .rstn_i(rstn_i),
      .istek_gecerli_i(istek_gecerli_i), .istek_hazir_o(istek_hazir_o),
      .istek_yaz_i(istek_yaz_i), .istek_adres_i(istek_adres_i),
      .istek_veri_i(istek_veri_i), .istek_maske_i(istek_maske_i),
      .istek_yedek_yaz_i(istek_yedek_yaz_i),
      .yanit_gecerli_o(yanit_gecerli_o), .yanit_hazir_i(yanit_hazir_i),
      .yanit_veri_o(yanit_veri_o),
      .sram_csb_o(sram_csb_o), .sram_web_o(sram_web_o),
      .sram_wmask_o(sram_wmask_o), .sram_spare_wen_o(sram_spare_wen_o),
      .sram_addr_o(sram_addr_o), .sram_din_o(sram_din_o),
      .sram_dout_i(sram_dout_i)
   );

   always #5 clk_i = ~clk_i;

   // Macro model: pins sampled at the rising edge, read data valid the following cycle.
   always @(posedge clk_i) begin
      if (!sram_csb_o) begin
         acc_cnt <= acc_cnt + 1;
         if (!sram_web_o) begin
            w = mem[sram_addr_o];
            for (int b = 0; b < 14; b++) begin
               if (sram_wmask_o[b]) w[8*b +: 8] = sram_din_o[8*b +: 8];
            end
            if (sram_spare_wen_o) w[112] = sram_din_o[112];
            mem[sram_addr_o] <= w;
         end else begin
            sram_dout_i <= mem[sram_addr_o];
         end
      end
   end

   // A push into a full FIFO would overwrite the head entry.
   always @(posedge clk_i) begin
      if (rstn_i && dut.ucusta && dut.doluluk == 2'd3 && !(yanit_gecerli_o && yanit_hazir_i)) begin
         ovf <= 1'b1;
      end
   end

   task automatic check(input string tag, input logic [112:0] got, input logic [112:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [112:0] data_of(input int i);
      logic [112:0] v;
      v = {8'(i), 97'h0, 8'(i) ^ 8'h5A};
      v[60 +: 8] = 8'(i * 7 + 3);
      return v;
   endfunction

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic istek(input logic yaz, input logic [7:0] a, input logic [112:0] d,
                        input logic [13:0] m, input logic s);
      int n;
      n = 0;
      istek_gecerli_i = 1'b1; istek_yaz_i = yaz; istek_adres_i = a;
      istek_veri_i = d; istek_maske_i = m; istek_yedek_yaz_i = s;
      @(negedge clk_i);
      while (!istek_hazir_o && n < 50) begin
         @(negedge clk_i);
         n++;
      end
      if (n >= 50) check("hazir_timeout", 1'b0, 1'b1);
      @(posedge clk_i); #1;
      istek_gecerli_i = 1'b0;
   endtask

   task automatic read_check(input logic [7:0] a, input logic [112:0] exp);
      istek_gecerli_i = 1'b1; istek_yaz_i = 1'b0; istek_adres_i = a;
      istek_maske_i = 14'h3FFF; istek_yedek_yaz_i = 1'b1;
      @(negedge clk_i);
      check("rd_hazir", istek_hazir_o, 1'b1);
      check("rd_csb", sram_csb_o, 1'b0);
      check("rd_web", sram_web_o, 1'b1);
      check("rd_wmask", sram_wmask_o, 14'h0);
      check("rd_spare", sram_spare_wen_o, 1'b0);
      @(posedge clk_i); #1;
      istek_gecerli_i = 1'b0;
      @(negedge clk_i);
      check("rd_valid_n1", yanit_gecerli_o, 1'b0);
      @(negedge clk_i);
      check("rd_valid_n2", yanit_gecerli_o, 1'b1);
      check("rd_data", yanit_veri_o, exp);
      @(posedge clk_i); #1;
   endtask

   initial begin
      int n_acc;
      int stale;
      logic acc;
      for (int i = 0; i < 256; i++) mem[i] = '0;
      sram_dout_i = '0;
      rstn_i = 1'b0; istek_gecerli_i = 1'b0; istek_yaz_i = 1'b0; istek_adres_i = '0;
      istek_veri_i = '0; istek_maske_i = '0; istek_yedek_yaz_i = 1'b0; yanit_hazir_i = 1'b1;

      repeat (3) @(posedge clk_i);
      istek_gecerli_i = 1'b1;
      @(negedge clk_i);
      check("rst_hazir", istek_hazir_o, 1'b0);
      check("rst_valid", yanit_gecerli_o, 1'b0);
      check("rst_data", yanit_veri_o, '0);
      check("rst_csb", sram_csb_o, 1'b1);
      check("rst_web", sram_web_o, 1'b1);
      check("rst_wmask", sram_wmask_o, 14'h0);
      check("rst_spare", sram_spare_wen_o, 1'b0);
      istek_gecerli_i = 1'b0;
      @(posedge clk_i); #1;
      rstn_i = 1'b1;
      #1 check("rel_hazir", istek_hazir_o, 1'b1);
      @(posedge clk_i); #1;

      // Full write to 0x05 with pin checks, then read back.
      istek_gecerli_i = 1'b1; istek_yaz_i = 1'b1; istek_adres_i = 8'h05;
      istek_veri_i = '1; istek_maske_i = 14'h3FFF; istek_yedek_yaz_i = 1'b1;
      @(negedge clk_i);
      check("wr_csb", sram_csb_o, 1'b0);
      check("wr_web", sram_web_o, 1'b0);
      check("wr_wmask", sram_wmask_o, 14'h3FFF);
      check("wr_spare", sram_spare_wen_o, 1'b1);
      check("wr_addr", sram_addr_o, 8'h05);
      @(posedge clk_i); #1;
      istek_gecerli_i = 1'b0;
      read_check(8'h05, '1);

      // Partial mask; the read follows the second write back to back.
      istek(1'b1, 8'h10, '0, 14'h3FFF, 1'b1);
      istek(1'b1, 8'h10, '1, 14'h0001, 1'b0);
      read_check(8'h10, 113'hFF);

      // Preload 0..15, then one read per cycle.
      for (int i = 0; i < 16; i++) istek(1'b1, 8'(i), data_of(i), 14'h3FFF, 1'b1);
      @(posedge clk_i); #1;
      for (int c = 0; c < 18; c++) begin
         istek_gecerli_i = (c < 16); istek_yaz_i = 1'b0; istek_adres_i = 8'(c);
         @(negedge clk_i);
         if (c < 16) check("b2b_hazir", istek_hazir_o, 1'b1);
         if (c >= 2) begin
            check("b2b_valid", yanit_gecerli_o, 1'b1);
            check("b2b_data", yanit_veri_o, data_of(c - 2));
         end
         @(posedge clk_i); #1;
      end
      istek_gecerli_i = 1'b0;
      @(negedge clk_i);
      check("b2b_empty", yanit_gecerli_o, 1'b0);
      @(posedge clk_i); #1;

      // Backpressure: consumer stalled.
      yanit_hazir_i = 1'b0;
      n_acc = 0;
      istek_gecerli_i = 1'b1; istek_yaz_i = 1'b0;
      for (int c = 0; c < 8; c++) begin
         istek_adres_i = 8'(n_acc);
         @(negedge clk_i);
         acc = istek_hazir_o;
         @(posedge clk_i); #1;
         if (acc) n_acc++;
      end
      @(negedge clk_i);
      check("bp_accepted", 113'(n_acc), 113'd3);
      check("bp_hazir", istek_hazir_o, 1'b0);
      check("bp_head", yanit_veri_o, data_of(0));
      @(posedge clk_i); #1;
      istek_gecerli_i = 1'b0;
      yanit_hazir_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk_i);
         check("bp_valid", yanit_gecerli_o, 1'b1);
         check("bp_data", yanit_veri_o, data_of(k));
         @(posedge clk_i); #1;
      end
      @(negedge clk_i);
      check("bp_empty", yanit_gecerli_o, 1'b0);
      @(posedge clk_i); #1;

      // Reset with two entries stored and one read in flight.
      yanit_hazir_i = 1'b0;
      istek_gecerli_i = 1'b1; istek_yaz_i = 1'b0;
      for (int c = 0; c < 3; c++) begin
         istek_adres_i = 8'(c + 4);
         @(posedge clk_i); #1;
      end
      istek_gecerli_i = 1'b0;
      check("mr_pre_valid", yanit_gecerli_o, 1'b1);
      #2 rstn_i = 1'b0;
      #1;
      check("mr_valid", yanit_gecerli_o, 1'b0);
      check("mr_data", yanit_veri_o, '0);
      check("mr_csb", sram_csb_o, 1'b1);
      check("mr_hazir", istek_hazir_o, 1'b0);
      repeat (2) @(posedge clk_i);
      #1 rstn_i = 1'b1;
      yanit_hazir_i = 1'b1;
      stale = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk_i);
         if (yanit_gecerli_o) stale++;
      end
      check("mr_stale", 113'(stale), 113'd0);
      @(posedge clk_i); #1;

      // Idle.
      n_acc = acc_cnt;
      repeat (20) @(posedge clk_i);
      @(negedge clk_i);
      check("idle_access", 113'(acc_cnt - n_acc), 113'd0);
      check("idle_csb", sram_csb_o, 1'b1);

      check("no_full_push", ovf, 1'b0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
